// File: rtl/prog_sequencer_pkg.sv
// Shared types, widths and the program address lookup for the run sequencer.
package seq_pkg;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  typedef logic [3:0][PC_W-1:0] addr_tab_t;

  // Out-of-range selections fall back to program 0 rather than an unused slot.
  function automatic logic [PC_W-1:0] prog_addr(input logic [1:0] sel,
                                                input int         num_progs,
                                                input addr_tab_t  tab);
    if (int'(sel) >= num_progs) return tab[0];
    return tab[sel];
  endfunction

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Clearable up-counter that sticks at all-ones, with a compare against LIMIT.
module sat_counter
  import seq_pkg::*;
#(
  parameter int             W     = CNT_W,
  parameter logic [W-1:0]   LIMIT = '1
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_limit
);

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; a blocking = here would race with readers of count.
  always_ff @(posedge CLK) begin
    if (Reset || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: launches a selected program on the fetch unit, watches for
// Halt or the cycle watchdog, and reports completion over a Req/Done handshake.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int              NUM_PROGS     = 4,
  parameter int              MAX_CYCLES    = 16'hFFFF,
  parameter int              LAUNCH_CYCLES = 1,
  parameter logic [PC_W-1:0] PROG_ADDR0    = 8'd0,
  parameter logic [PC_W-1:0] PROG_ADDR1    = 8'd64,
  parameter logic [PC_W-1:0] PROG_ADDR2    = 8'd128,
  parameter logic [PC_W-1:0] PROG_ADDR3    = 8'd192
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req,
  input  logic [1:0]        Prog_Sel,
  input  logic              Halt,
  input  logic [PC_W-1:0]   PC,
  output logic              Start,
  output logic [PC_W-1:0]   Start_Addr,
  output logic              Busy,
  output logic              Done,
  output logic              Timeout,
  output logic [CNT_W-1:0]  Cycle_Count,
  output logic [PC_W-1:0]   Halt_PC
);

  localparam addr_tab_t ADDR_TAB = {PROG_ADDR3, PROG_ADDR2, PROG_ADDR1, PROG_ADDR0};

  state_t             state;
  logic               cyc_at_limit;
  logic               hold_done;
  logic [CNT_W-1:0]   hold_count;
  logic               unused_hold;

  // The terminating RUN cycle is not counted, so a watchdog run reports
  // MAX_CYCLES-1 and a halt reports the count visible on the halt cycle.
  sat_counter #(
    .W     (CNT_W),
    .LIMIT (CNT_W'(MAX_CYCLES - 1))
  ) u_cycle_cnt (
    .CLK      (CLK),
    .Reset    (Reset),
    .clr      ((state == IDLE) && Req),
    .en       ((state == RUN) && !Halt && !cyc_at_limit),
    .count    (Cycle_Count),
    .at_limit (cyc_at_limit)
  );

  sat_counter #(
    .W     (CNT_W),
    .LIMIT (CNT_W'(LAUNCH_CYCLES - 1))
  ) u_hold_cnt (
    .CLK      (CLK),
    .Reset    (Reset),
    .clr      (state != LAUNCH),
    .en       (state == LAUNCH),
    .count    (hold_count),
    .at_limit (hold_done)
  );

  assign unused_hold = ^hold_count;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      Start      <= 1'b1;
      Start_Addr <= PROG_ADDR0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Timeout    <= 1'b0;
      Halt_PC    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Req) begin
            state      <= LAUNCH;
            Start_Addr <= prog_addr(Prog_Sel, NUM_PROGS, ADDR_TAB);
            Busy       <= 1'b1;
            Timeout    <= 1'b0;
          end
        end
        // Halt is ignored here: decode still holds the previous program's state.
        LAUNCH: begin
          if (hold_done) begin
            state <= RUN;
            Start <= 1'b0;
          end
        end
        RUN: begin
          if (Halt) begin
            Halt_PC <= PC;
            state   <= DONE;
            Start   <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b1;
          end else if (cyc_at_limit) begin
            Timeout <= 1'b1;
            state   <= DONE;
            Start   <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b1;
          end
        end
        DONE: begin
          if (!Req) begin
            state <= IDLE;
            Done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scenario bench for prog_sequencer: expected run results are queued at launch
// and compared when Done is observed.
module tb_prog_sequencer;

  localparam int NP   = 3;
  localparam int MAXC = 20;
  localparam int LC   = 2;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req;
  logic [1:0]  Prog_Sel;
  logic        Halt;
  logic [7:0]  PC;
  logic        Start;
  logic [7:0]  Start_Addr;
  logic        Busy;
  logic        Done;
  logic        Timeout;
  logic [15:0] Cycle_Count;
  logic [7:0]  Halt_PC;

  typedef struct {
    logic [7:0]  addr;
    logic        timeout;
    logic [15:0] count;
    logic [7:0]  halt_pc;
  } exp_t;

  exp_t       sb[$];
  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] model_halt_pc;

  prog_sequencer #(
    .NUM_PROGS     (NP),
    .MAX_CYCLES    (MAXC),
    .LAUNCH_CYCLES (LC)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Req         (Req),
    .Prog_Sel    (Prog_Sel),
    .Halt        (Halt),
    .PC          (PC),
    .Start       (Start),
    .Start_Addr  (Start_Addr),
    .Busy        (Busy),
    .Done        (Done),
    .Timeout     (Timeout),
    .Cycle_Count (Cycle_Count),
    .Halt_PC     (Halt_PC)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 1'b0; Prog_Sel = 2'd0; Halt = 1'b0; PC = 8'h00;
    repeat (2) tick();
    Reset = 1'b0;
    model_halt_pc = 8'h00;
    for (int i = 0; i < 16; i++) begin
      tick();
      compared++;
      if (Start !== 1'b1 || Start_Addr !== 8'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_park[%0d]: got Start=%b Addr=%0d Busy=%b Done=%b, expected 1 0 0 0",
                 i, Start, Start_Addr, Busy, Done);
      end
    end
    compared++;
    if (Timeout !== 1'b0 || Cycle_Count !== 16'd0 || Halt_PC !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_regs: got Timeout=%b Count=%0d HaltPC=%0d, expected 0 0 0",
               Timeout, Cycle_Count, Halt_PC);
    end
  endtask

  // halt_at < 0 means no Halt; the watchdog must end the run.
  task automatic do_run(input logic [1:0] sel, input int halt_at, input bit halt_in_launch,
                        input bit drop_req, output logic [15:0] cnt);
    exp_t       e;
    logic [7:0] pc_v;
    bit         seen;
    seen = 1'b0;
    pc_v = 8'($urandom);
    e.addr = (int'(sel) >= NP) ? 8'd0 : 8'(64 * int'(sel));
    if (halt_at >= 0 && halt_at < MAXC) begin
      e.timeout = 1'b0; e.count = 16'(halt_at); e.halt_pc = pc_v;
    end else begin
      e.timeout = 1'b1; e.count = 16'(MAXC - 1); e.halt_pc = model_halt_pc;
    end
    sb.push_back(e);

    Req = 1'b1; Prog_Sel = sel;
    tick();
    compared++;
    if (Start_Addr !== e.addr) begin
      mismatched++;
      $display("FAIL launch_addr: got %0d expected %0d", Start_Addr, e.addr);
    end
    compared++;
    if (Start !== 1'b1 || Busy !== 1'b1 || Done !== 1'b0 || Timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL launch_flags: got Start=%b Busy=%b Done=%b Timeout=%b, expected 1 1 0 0",
               Start, Busy, Done, Timeout);
    end

    Halt = halt_in_launch;
    repeat (LC) tick();
    Halt = 1'b0;
    compared++;
    if (Start !== 1'b0 || Busy !== 1'b1 || Cycle_Count !== 16'd0 || Done !== 1'b0) begin
      mismatched++;
      $display("FAIL run_entry: got Start=%b Busy=%b Count=%0d Done=%b, expected 0 1 0 0",
               Start, Busy, Cycle_Count, Done);
    end

    if (drop_req) Req = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      if (n == halt_at) begin
        Halt = 1'b1; PC = pc_v;
      end else begin
        PC = 8'($urandom);
      end
      tick();
      Halt = 1'b0;
      if (Done === 1'b1) seen = 1'b1;
    end

    e = sb.pop_front();
    cnt = e.count;
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL done_wait: got no Done within 64 cycles, expected Done=1");
    end else begin
      if (e.timeout == 1'b0) model_halt_pc = e.halt_pc;
      compared++;
      if (Timeout !== e.timeout) begin
        mismatched++;
        $display("FAIL done_timeout: got %b expected %b", Timeout, e.timeout);
      end
      compared++;
      if (Cycle_Count !== e.count) begin
        mismatched++;
        $display("FAIL done_count: got %0d expected %0d", Cycle_Count, e.count);
      end
      compared++;
      if (Halt_PC !== e.halt_pc) begin
        mismatched++;
        $display("FAIL done_halt_pc: got %0d expected %0d", Halt_PC, e.halt_pc);
      end
      compared++;
      if (Start !== 1'b1 || Busy !== 1'b0 || Start_Addr !== e.addr) begin
        mismatched++;
        $display("FAIL done_park: got Start=%b Busy=%b Addr=%0d, expected 1 0 %0d",
                 Start, Busy, Start_Addr, e.addr);
      end
    end
  endtask

  task automatic release_done(input bit hold, input logic [15:0] exp_count);
    if (hold) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        compared++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Start !== 1'b1) begin
          mismatched++;
          $display("FAIL done_hold[%0d]: got Done=%b Busy=%b Start=%b, expected 1 0 1",
                   i, Done, Busy, Start);
        end
      end
    end
    Req = 1'b0;
    tick();
    compared++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Start !== 1'b1) begin
      mismatched++;
      $display("FAIL release_idle: got Done=%b Busy=%b Start=%b, expected 0 0 1", Done, Busy, Start);
    end
    compared++;
    if (Cycle_Count !== exp_count) begin
      mismatched++;
      $display("FAIL count_frozen: got %0d expected %0d", Cycle_Count, exp_count);
    end
  endtask

  task automatic test_halt_run();
    logic [15:0] c;
    do_run(2'd2, 10, 1'b0, 1'b0, c);
    release_done(1'b0, c);
  endtask

  task automatic test_timeout();
    logic [15:0] c;
    do_run(2'd1, -1, 1'b0, 1'b0, c);
    release_done(1'b0, c);
    do_run(2'd0, MAXC - 1, 1'b0, 1'b0, c);
    release_done(1'b0, c);
  endtask

  task automatic test_out_of_range();
    logic [15:0] c;
    do_run(2'd3, 5, 1'b1, 1'b0, c);
    release_done(1'b0, c);
  endtask

  task automatic test_req_drop();
    logic [15:0] c;
    do_run(2'd1, -1, 1'b0, 1'b1, c);
    release_done(1'b0, c);
  endtask

  task automatic test_back_to_back();
    logic [15:0] c;
    do_run(2'd2, 3, 1'b0, 1'b0, c);
    release_done(1'b1, c);
    do_run(2'd1, 7, 1'b0, 1'b0, c);
    release_done(1'b0, c);
  endtask

  task automatic test_reset_mid_run();
    Req = 1'b1; Prog_Sel = 2'd1;
    tick();
    repeat (LC + 5) tick();
    Reset = 1'b1;
    tick();
    compared++;
    if (Start !== 1'b1 || Start_Addr !== 8'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      mismatched++;
      $display("FAIL midrun_reset_flags: got Start=%b Addr=%0d Busy=%b Done=%b, expected 1 0 0 0",
               Start, Start_Addr, Busy, Done);
    end
    compared++;
    if (Cycle_Count !== 16'd0 || Halt_PC !== 8'd0 || Timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL midrun_reset_regs: got Count=%0d HaltPC=%0d Timeout=%b, expected 0 0 0",
               Cycle_Count, Halt_PC, Timeout);
    end
    Reset = 1'b0; Req = 1'b0;
    model_halt_pc = 8'h00;
    repeat (3) tick();
    compared++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midrun_no_done: got Done=%b Busy=%b, expected 0 0", Done, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_halt_run();
    test_timeout();
    test_out_of_range();
    test_req_drop();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
